// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the toggle handshake responder.
package toggle_hs_pkg;

    // FSM encoding; 2'd3 is unreachable and recovered to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        ACK     = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Map any unreachable encoding back to IDLE so a corrupted state register
    // cannot lock the handshake up.
    function automatic state_t recoverState(input state_t s);
        return (s == ILLEGAL) ? IDLE : s;
    endfunction

endpackage

// File: rtl/toggle_hs_responder_sync.sv
// Multi-flop synchroniser for the request toggle plus a history flop that
// turns each toggle flip into a single-cycle event pulse.
module toggle_sync
    import toggle_hs_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tgl,
    output logic o_evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_syncOut;

    assign w_syncOut = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous toggle through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
        end
    end

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= w_syncOut;
        end
    end

    assign o_evt = w_syncOut ^ r_hist;

endmodule

// File: rtl/toggle_hs_responder.sv
// Responder end of a 2-phase toggle handshake: synchronise the request,
// capture the payload, hand it to a valid/ready sink, then flip the ack.
module toggle_hs_responder
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overrun,
    output logic              busy
);

    state_t              r_state;
    state_t              w_stateNext;
    logic                w_reqEvt;
    logic                w_capture;
    logic                w_accept;
    logic                w_ackFire;
    logic                w_violation;
    logic                r_ackTgl;
    logic [DATA_W-1:0]   r_dout;
    logic                r_doutValid;
    logic [CNT_W-1:0]    r_evtCount;
    logic                r_overrun;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tgl (req_tgl),
        .o_evt (w_reqEvt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        w_stateNext = recoverState(r_state);
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_ackFire   = 1'b0;
        w_violation = 1'b0;
        case (recoverState(r_state))
            IDLE: begin
                if (w_reqEvt) begin
                    w_capture   = 1'b1;
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                w_violation = w_reqEvt;
                if (r_doutValid && dout_ready) begin
                    w_accept    = 1'b1;
                    w_stateNext = ACK;
                end
            end
            ACK: begin
                w_violation = w_reqEvt;
                w_ackFire   = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Payload register: loaded only when leaving IDLE, so dout keeps the
    // last accepted word while dout_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_capture) begin
            r_dout <= req_data;
        end
    end

    // Valid flag: set on capture, cleared on sink acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_doutValid <= 1'b0;
        end else if (w_capture) begin
            r_doutValid <= 1'b1;
        end else if (w_accept) begin
            r_doutValid <= 1'b0;
        end
    end

    // Acknowledge toggle and transaction counter advance together in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ackTgl   <= 1'b0;
            r_evtCount <= '0;
        end else if (w_ackFire) begin
            r_ackTgl   <= ~r_ackTgl;
            r_evtCount <= r_evtCount + CNT_W'(1);
        end
    end

    // Sticky flag for a request flip that arrives mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_violation) begin
            r_overrun <= 1'b1;
        end
    end

    assign ack_tgl    = r_ackTgl;
    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign evt_count  = r_evtCount;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Bench for toggle_hs_responder: a full-width instance and a 2-bit-counter
// instance share one stimulus stream so the counter wrap is seen directly.
module tb_toggle_hs_responder;

    typedef struct {
        logic [7:0] data;
        int         readyDelay;
        int         expCount8;
        int         expCount2;
        logic       expAck;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       dout_ready;

    logic       ack_tgl,    ackW;
    logic [7:0] dout,       doutW;
    logic       dout_valid, validW;
    logic [7:0] evt_count;
    logic [1:0] countW;
    logic       overrun,    overrunW;
    logic       busy,       busyW;

    int         nChecks;
    int         nErrors;
    int         expCount;
    logic       expAck;
    logic [7:0] sbQueue[$];
    vec_t       vecs[5];

    toggle_hs_responder #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_tgl    (req_tgl),
        .req_data   (req_data),
        .ack_tgl    (ack_tgl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .evt_count  (evt_count),
        .overrun    (overrun),
        .busy       (busy)
    );

    toggle_hs_responder #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(2)) dutWrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_tgl    (req_tgl),
        .req_data   (req_data),
        .ack_tgl    (ackW),
        .dout       (doutW),
        .dout_valid (validW),
        .dout_ready (dout_ready),
        .evt_count  (countW),
        .overrun    (overrunW),
        .busy       (busyW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flip the request toggle with a new payload and record the expected word.
    task automatic applyStimulus(input logic [7:0] data, input int readyDelay);
        dout_ready = (readyDelay == 0);
        req_data   = data;
        req_tgl    = ~req_tgl;
        sbQueue.push_back(data);
    endtask

    // Wait (bounded) for dout_valid and check the synchroniser latency.
    task automatic waitValid(input string tag);
        int cyc = 0;
        while (!dout_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, 3);
        checkOutput({tag, "_validWrap"}, validW, 1);
    endtask

    // Hold off the sink for readyDelay cycles, then accept and check the ack.
    task automatic completeHandshake(input string tag, input logic [7:0] data, input int readyDelay);
        logic [7:0] expData;
        for (int k = 0; k < readyDelay; k++) begin
            checkOutput({tag, "_holdValid"}, dout_valid, 1);
            checkOutput({tag, "_holdDout"}, dout, data);
            checkOutput({tag, "_holdAck"}, ack_tgl, expAck);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        if (sbQueue.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 1, 0);
            expData = 8'h00;
        end else begin
            expData = sbQueue.pop_front();
        end
        checkOutput({tag, "_sbDout"}, dout, expData);
        @(negedge clk);
        checkOutput({tag, "_acceptValid"}, dout_valid, 0);
        checkOutput({tag, "_acceptAck"}, ack_tgl, expAck);
        checkOutput({tag, "_acceptBusy"}, busy, 1);
        @(negedge clk);
        expAck   = ~expAck;
        expCount = expCount + 1;
        checkOutput({tag, "_ack"}, ack_tgl, expAck);
        checkOutput({tag, "_ackWrap"}, ackW, expAck);
        checkOutput({tag, "_count"}, evt_count, expCount % 256);
        checkOutput({tag, "_countWrap"}, countW, expCount % 4);
        checkOutput({tag, "_idleBusy"}, busy, 0);
        checkOutput({tag, "_retainDout"}, dout, data);
    endtask

    initial begin
        nChecks    = 0;
        nErrors    = 0;
        expCount   = 0;
        expAck     = 1'b0;
        rst_n      = 1'b0;
        req_tgl    = 1'b0;
        req_data   = 8'h00;
        dout_ready = 1'b0;

        vecs[0] = '{8'hA5, 0,  1, 1, 1'b1};
        vecs[1] = '{8'h3C, 10, 2, 2, 1'b0};
        vecs[2] = '{8'hC3, 0,  3, 3, 1'b1};
        vecs[3] = '{8'h0F, 2,  4, 0, 1'b0};
        vecs[4] = '{8'hF0, 0,  5, 1, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("rst_ack", ack_tgl, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_count", evt_count, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_valid", dout_valid, 0);

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].readyDelay);
            waitValid("tbl");
            completeHandshake("tbl", vecs[i].data, vecs[i].readyDelay);
            checkOutput("tbl_expCount8", evt_count, vecs[i].expCount8);
            checkOutput("tbl_expCount2", countW, vecs[i].expCount2);
            checkOutput("tbl_expAck", ack_tgl, vecs[i].expAck);
            checkOutput("tbl_overrun", overrun, 0);
            @(negedge clk);
        end

        $display("[TB] overrun sequence");
        applyStimulus(8'h11, 1);
        waitValid("ovr");
        req_data = 8'h22;
        req_tgl  = ~req_tgl;
        repeat (5) @(negedge clk);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_flagWrap", overrunW, 1);
        checkOutput("ovr_keepDout", dout, 8'h11);
        checkOutput("ovr_keepValid", dout_valid, 1);
        completeHandshake("ovr", 8'h11, 0);
        repeat (4) @(negedge clk);
        checkOutput("ovr_noExtraCount", evt_count, expCount);
        checkOutput("ovr_noExtraValid", dout_valid, 0);
        checkOutput("ovr_sticky", overrun, 1);
        applyStimulus(8'h66, 0);
        waitValid("post");
        completeHandshake("post", 8'h66, 0);
        checkOutput("post_sticky", overrun, 1);
        @(negedge clk);

        $display("[TB] reset in HOLD");
        applyStimulus(8'h77, 1);
        waitValid("rstHold");
        @(negedge clk);
        checkOutput("rstHold_busyBefore", busy, 1);
        #2;
        rst_n   = 1'b0;
        req_tgl = 1'b0;
        #1;
        checkOutput("rstHold_valid", dout_valid, 0);
        checkOutput("rstHold_busy", busy, 0);
        checkOutput("rstHold_ack", ack_tgl, 0);
        checkOutput("rstHold_overrun", overrun, 0);
        checkOutput("rstHold_count", evt_count, 0);
        sbQueue.delete();
        expAck   = 1'b0;
        expCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rstHold_noEvtValid", dout_valid, 0);
            checkOutput("rstHold_noEvtBusy", busy, 0);
        end

        $display("[TB] reset release with req_tgl high");
        rst_n      = 1'b0;
        req_tgl    = 1'b1;
        req_data   = 8'h5A;
        dout_ready = 1'b1;
        sbQueue.push_back(8'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        waitValid("rstHigh");
        completeHandshake("rstHigh", 8'h5A, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rstHigh_single", dout_valid, 0);
        end
        checkOutput("rstHigh_count", evt_count, 1);
        checkOutput("rstHigh_sbDrained", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/toggle_hs_responder.md
Name: toggle_hs_responder

Overview:
- Responder end of a 2-phase (toggle) request/acknowledge handshake.
- The initiator signals each event by flipping req_tgl, which is a T-flop style level, and holds req_data stable until ack_tgl flips back.
- This block synchronises req_tgl into the local clock domain, captures req_data, and presents it on a valid/ready sink port.
- It returns ack_tgl only after the sink accepts the word, and it counts completed transactions.

Parameters:
- DATA_W, 8, width of req_data and dout.
- SYNC_STAGES, 2, number of synchroniser flops on req_tgl; legal range is 2 to 4.
- CNT_W, 8, width of the transaction counter.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- req_tgl  input  1  request toggle from the initiator; asynchronous to clk.
- req_data  input  DATA_W  payload; stable from the req_tgl flip until the ack_tgl flip.
- ack_tgl  output  1  acknowledge toggle back to the initiator.
- dout  output  DATA_W  captured payload.
- dout_valid  output  1  dout holds an unaccepted word.
- dout_ready  input  1  sink accepts dout when dout_valid and dout_ready are both high.
- evt_count  output  CNT_W  number of completed handshakes.
- overrun  output  1  sticky protocol-violation flag.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset (decided):
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
- Reset values:
  - ack_tgl=0, dout=0, dout_valid=0, evt_count=0, overrun=0, busy=0.
  - All synchroniser flops and the edge-detect history flop reset to 0.
  - FSM resets to IDLE.
- Protocol reset state:
  - Both toggles are 0 at reset.
  - If req_tgl is 1 when rst_n deasserts, exactly one event is detected. This is the specified behaviour, not a bug.
- Edge detect:
  - req_evt = sync_out XOR sync_q, where sync_q is sync_out delayed by one flop.
  - req_evt is a single-cycle pulse per req_tgl flip.
- FSM states: IDLE, HOLD, ACK.
- IDLE:
  - On req_evt, register dout <= req_data and dout_valid <= 1, then go to HOLD.
  - Latency: a req_tgl flip produces dout_valid high SYNC_STAGES+1 clk edges later, plus up to one cycle of synchroniser uncertainty.
- HOLD:
  - dout_valid stays high and dout stays stable until dout_valid and dout_ready are both high on a clk edge.
  - On that edge, dout_valid <= 0, then go to ACK.
  - If dout_ready is already high when dout_valid rises, acceptance occurs on the very next edge. There is no bubble.
- ACK:
  - Flip ack_tgl, increment evt_count, return to IDLE; this takes one cycle.
  - evt_count wraps modulo 2^CNT_W; 2^CNT_W-1 rolls over to 0.
- Minimum turnaround: a req flip yields an ack flip after SYNC_STAGES+3 cycles when dout_ready is held high.
- Overrun:
  - A req_evt in HOLD or ACK is a protocol violation.
  - It sets overrun, which stays at 1 until reset.
  - The event is dropped: no capture, no extra ack, no count.
  - The current transaction completes normally.
- Data rule: req_data is sampled only on the IDLE-to-HOLD edge. It is never sampled through the synchroniser and never sampled in other states.
- dout is unchanged while dout_valid is low, so it retains the last accepted word.
- Reset mid-operation returns the block to the reset values immediately and asynchronously. Any in-flight word is lost. The initiator must also reset its toggle to 0.
- busy = (state != IDLE).

Decomposition:
- Shared package toggle_hs_pkg contains:
  - the state typedef: IDLE=2'd0, HOLD=2'd1, ACK=2'd2, 2'd3 illegal;
  - the default SYNC_STAGES constant;
  - an illegal-state recovery policy: decode 2'd3 to IDLE.
- The natural sub-module is toggle_sync: SYNC_STAGES-deep synchroniser plus history flop, outputting req_evt and sync_out.
- The top level holds the FSM, the data register, the counter and the overrun flag.

Test Plan:
- Reset, then one req_tgl 0->1 with req_data=8'hA5 and dout_ready=1 → dout_valid rises 3 edges after the flip (SYNC_STAGES=2), dout=8'hA5; ack_tgl 0->1 two edges later; evt_count=1.
- Backpressure: dout_ready=0 for 10 cycles after valid, req_data=8'h3C → dout_valid and dout=8'h3C held all 10 cycles, ack_tgl unchanged; raise dout_ready → ack_tgl flips 2 edges later.
- Second flip before ack (overrun) → overrun=1 and stays 1; evt_count advances by 1 only; next legal transaction still completes with overrun still 1.
- Counter wrap with CNT_W=2: 5 back-to-back legal transactions → evt_count sequence 1,2,3,0,1; ack_tgl ends at 1.
- Assert rst_n low while in HOLD → dout_valid, busy and ack_tgl drop to 0 immediately without waiting for a clock; after release with req_tgl=0, no event is detected.
- Release reset with req_tgl=1 → exactly one event is captured and evt_count=1 after dout_ready acceptance.
